audio_app: RTL and testbench
============================

AUDIO_APP -- requirements
Module: audio_app

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports di_0..di_3, input, 16 bits each: signed two's-complement audio samples, channels 0-3.
REQ-004 SHALL have ports do_0..do_3, output, 16 bits each: registered processed samples, channels 0-3.
REQ-005 SHALL have port prgrm_in, input, 1 bit: serial program data, sampled only while prgrm_go_ is low.
REQ-006 SHALL have port prgrm_go_, input, 1 bit: program window, active-low.
REQ-007 SHALL have port err_, output, 1 bit: programming error flag, active-low, registered.

Function
REQ-008 SHALL hold a 3-bit mode register per channel.
REQ-009 Each cycle, do_n SHALL be f(mode_n, di_n) registered, giving one-cycle latency; the datapath runs regardless of programming activity.
REQ-010 Mode encoding SHALL be:
  - 000 pass
  - 001 mute (0x0000)
  - 010 negate
  - 011 arithmetic shift right 1
  - 100 arithmetic shift right 2
  - 101 shift left 1 (x2)
  - 110 absolute value
  - 111 pass (reserved)
REQ-011 A program window SHALL be a run of consecutive cycles with prgrm_go_ low; one bit is sampled per low cycle.
REQ-012 Command format SHALL be exactly 6 bits, first-sampled bit first: opcode (must be 0), channel[1:0] MSB first, mode[2:0] MSB first.
REQ-013 On the edge where prgrm_go_ is sampled high after exactly 6 low cycles with no error, the selected channel's mode SHALL update; the new mode applies to do_n from the following edge.
REQ-014 An opcode bit of 1 SHALL drive err_ low on the edge after that bit is sampled; the rest of that window SHALL be ignored.
REQ-015 A window of 1-5 cycles SHALL drive err_ low on the edge that samples prgrm_go_ high; no mode update occurs.
REQ-016 A seventh consecutive low cycle SHALL drive err_ low on that edge; no mode update occurs for that window.
REQ-017 err_ SHALL stay low until a new window starts or reset asserts; the first low cycle of a window releases err_ to high, except that an error detected in that same cycle (REQ-014) takes priority and err_ goes low.
REQ-018 prgrm_in SHALL be ignored while prgrm_go_ is high.
REQ-019 An erroneous window SHALL leave all mode registers unchanged.

Reset
REQ-020 While rst_ is low, all of the following SHALL hold immediately, independent of clk:
  - do_0..do_3 = 0x0000
  - all modes = 000
  - err_ = 1
  - program shift/count state cleared
REQ-021 Reset asserted mid-window SHALL discard the partial command; after reset release, a window counts from its first low cycle sampled after release.

Configuration
REQ-022 Macro AUDIO_APP_SAT_EN SHALL select overflow handling for modes 010, 101 and 110.
REQ-023 With AUDIO_APP_SAT_EN defined, overflow SHALL saturate:
  - negate/abs of 0x8000 gives 0x7FFF
  - x2 clamps to 0x7FFF or 0x8000
REQ-024 Without AUDIO_APP_SAT_EN, overflow SHALL wrap in two's complement:
  - negate/abs of 0x8000 gives 0x8000
  - x2 discards the MSB

Verification
REQ-025 Reset check: rst_ low for 10 cycles, then high, di_0 = 0x00F8, no program -> do_0 = 0x00F8 one cycle later, err_ = 1; reasserting rst_ -> do_0..do_3 = 0x0000 immediately.
REQ-026 Valid program: prgrm_go_ low 6 cycles with bits 0,0,0,0,0,1 (ch0 mute), then high -> err_ stays 1; do_0 = 0x0000 from the second edge after prgrm_go_ rises, with di_0 = 0x00F8.
REQ-027 Opcode error: window with first bit 1, sequence 1,0,0,1,1,1 -> err_ = 0 on the edge after the first bit; modes unchanged; di_0 = 0xFF00 -> do_0 = 0xFF00.
REQ-028 Short window: prgrm_go_ low for 3 cycles -> err_ = 0 on the edge after prgrm_go_ rises; a following valid 6-bit window clears err_ at its first low cycle.
REQ-029 Long window: prgrm_go_ low for 7 cycles -> err_ = 0 at the seventh cycle; no mode change.
REQ-030 Arithmetic: program ch1 mode 101, di_1 = 0x4001 -> do_1 = 0x7FFF with AUDIO_APP_SAT_EN, 0x8002 without; program ch2 mode 011, di_2 = 0xFF00 -> do_2 = 0xFF80.

Source files
------------

// File: rtl/audio_app.sv
// -----------------------------------------------------------------------------
// audio_app
//   Four-channel 16-bit audio sample processor with a serial programming port.
//   Each channel owns a 3-bit mode register that selects the operation applied
//   to its input sample; the result is registered (one-cycle latency).  Modes
//   are loaded through a 6-bit serial command clocked in while prgrm_go_ is low.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_       in   1   asynchronous reset, active-low
//   di_0..di_3 in  16   signed input samples, channels 0-3
//   do_0..do_3 out 16   registered processed samples, channels 0-3
//   prgrm_in   in   1   serial command data, sampled while prgrm_go_ is low
//   prgrm_go_  in   1   program window, active-low
//   err_       out  1   programming error flag, active-low, registered
//
// Modes
//   000 pass   001 mute   010 negate   011 asr 1   100 asr 2
//   101 x2     110 abs    111 pass
//
// Command (first-sampled bit first)
//   opcode(=0), channel[1:0] MSB first, mode[2:0] MSB first
//
// Configuration
//   AUDIO_APP_SAT_EN  defined   : negate/abs/x2 saturate on overflow
//                     undefined : negate/abs/x2 wrap in two's complement
// -----------------------------------------------------------------------------
module audio_app (
    input  logic        clk,
    input  logic        rst_,
    input  logic [15:0] di_0,
    input  logic [15:0] di_1,
    input  logic [15:0] di_2,
    input  logic [15:0] di_3,
    output logic [15:0] do_0,
    output logic [15:0] do_1,
    output logic [15:0] do_2,
    output logic [15:0] do_3,
    input  logic        prgrm_in,
    input  logic        prgrm_go_,
    output logic        err_
);

    // IDLE : no window in progress
    // RECV : collecting command bits of a window that is still valid
    // DROP : window already in error, remaining low cycles are ignored
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } prog_state_e;

    localparam logic [2:0] CMD_LEN = 3'd6;

    prog_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;      // low cycles seen in the current window
    logic [4:0]        shift_q, shift_d;  // {channel[1:0], mode[2:0]} once complete
    logic              err_q, err_d;
    logic [3:0][2:0]   mode_q, mode_d;
    logic [3:0][15:0]  di_w;
    logic [3:0][15:0]  do_q, do_d;

    assign di_w = {di_3, di_2, di_1, di_0};

    // -------------------------------------------------------------------------
    // Sample arithmetic
    // -------------------------------------------------------------------------
    function automatic logic [15:0] negate(input logic [15:0] x);
`ifdef AUDIO_APP_SAT_EN
        // -(-32768) is not representable: clamp to the largest positive value
        if (x == 16'h8000) begin
            return 16'h7FFF;
        end
        return ~x + 16'd1;
`else
        return ~x + 16'd1;
`endif
    endfunction

    function automatic logic [15:0] double(input logic [15:0] x);
`ifdef AUDIO_APP_SAT_EN
        // Overflow exactly when the two top bits differ; clamp toward the sign
        if (x[15] ^ x[14]) begin
            return x[15] ? 16'h8000 : 16'h7FFF;
        end
        return {x[14:0], 1'b0};
`else
        return {x[14:0], 1'b0};
`endif
    endfunction

    function automatic logic [15:0] process(input logic [2:0] mode, input logic [15:0] x);
        logic [15:0] r;
        r = x;
        case (mode)
            3'b001:  r = '0;
            3'b010:  r = negate(x);
            3'b011:  r = {x[15], x[15:1]};
            3'b100:  r = {{2{x[15]}}, x[15:2]};
            3'b101:  r = double(x);
            3'b110:  r = x[15] ? negate(x) : x;
            default: r = x;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Datapath: runs every cycle regardless of programming activity
    // -------------------------------------------------------------------------
    always_comb begin
        do_d = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            do_d[n] = process(mode_q[n], di_w[n]);
        end
    end

    // -------------------------------------------------------------------------
    // Programming FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        err_d   = err_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (!prgrm_go_) begin
                    // First low cycle: this bit is the opcode.  A bad opcode
                    // wins over the release of err_ in the same cycle.
                    if (prgrm_in) begin
                        err_d   = 1'b0;
                        state_d = ST_DROP;
                    end else begin
                        err_d   = 1'b1;
                        cnt_d   = 3'd1;
                        shift_d = '0;
                        state_d = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                if (!prgrm_go_) begin
                    if (cnt_q == CMD_LEN) begin
                        // Seventh low cycle: window too long
                        err_d   = 1'b0;
                        state_d = ST_DROP;
                    end else begin
                        shift_d = {shift_q[3:0], prgrm_in};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end else begin
                    if (cnt_q == CMD_LEN) begin
                        mode_d[shift_q[4:3]] = shift_q[2:0];
                    end else begin
                        err_d = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (prgrm_go_) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            err_q   <= 1'b1;
            mode_q  <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            do_q    <= do_d;
        end
    end

    assign do_0 = do_q[0];
    assign do_1 = do_q[1];
    assign do_2 = do_q[2];
    assign do_3 = do_q[3];
    assign err_ = err_q;

endmodule

// File: tb/tb_audio_app.sv
module tb_audio_app;

    logic        clk = 1'b0;
    logic        rst_;
    logic [15:0] di [4];
    logic [15:0] do0, do1, do2, do3;
    logic        pin;
    logic        go;
    logic        err_w;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mode_m [4];
    logic        exp_err;
    logic [15:0] exp_do [4];
    int          win_len;
    bit          win_bits [$];

`ifdef AUDIO_APP_SAT_EN
    localparam logic [15:0] EXP_X2_4001 = 16'h7FFF;
`else
    localparam logic [15:0] EXP_X2_4001 = 16'h8002;
`endif

    audio_app dut (
        .clk       (clk),
        .rst_      (rst_),
        .di_0      (di[0]),
        .di_1      (di[1]),
        .di_2      (di[2]),
        .di_3      (di[3]),
        .do_0      (do0),
        .do_1      (do1),
        .do_2      (do2),
        .do_3      (do3),
        .prgrm_in  (pin),
        .prgrm_go_ (go),
        .err_      (err_w)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_do(input int n);
        case (n)
            0:       return do0;
            1:       return do1;
            2:       return do2;
            default: return do3;
        endcase
    endfunction

    function automatic int fdiv(input int v, input int d);
        int q;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // Mathematical meaning of each mode on the integer value, then fit to 16 bits
    function automatic logic [15:0] ref_f(input int m, input logic [15:0] x);
        int v;
        int r;
        v = int'($signed(x));
        case (m)
            1:       r = 0;
            2:       r = -v;
            3:       r = fdiv(v, 2);
            4:       r = fdiv(v, 4);
            5:       r = 2 * v;
            6:       r = (v < 0) ? -v : v;
            default: r = v;
        endcase
`ifdef AUDIO_APP_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return 16'(r);
    endfunction

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 6))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h4000 | 16'($urandom_range(0, 255));
            3:       return 16'hC000 - 16'($urandom_range(0, 255));
            4:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            mode_m[n] = 0;
            exp_do[n] = 16'h0000;
        end
        exp_err = 1'b1;
        win_len = 0;
        win_bits.delete();
    endtask

    // Advance one clock: update the model with the inputs present before the
    // edge, then wait for the edge and settle.
    task automatic tick();
        int ch;
        for (int n = 0; n < 4; n++) exp_do[n] = ref_f(mode_m[n], di[n]);
        if (!go) begin
            win_len++;
            if (win_len <= 6) win_bits.push_back(pin);
            if (win_len == 1) exp_err = !pin;
            else if (win_len == 7) exp_err = 1'b0;
        end else if (win_len > 0) begin
            if (win_bits[0] == 1'b0) begin
                if (win_len == 6) begin
                    ch = int'(win_bits[1]) * 2 + int'(win_bits[2]);
                    mode_m[ch] = int'(win_bits[3]) * 4 + int'(win_bits[4]) * 2 + int'(win_bits[5]);
                end else if (win_len < 6) begin
                    exp_err = 1'b0;
                end
            end
            win_len = 0;
            win_bits.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        go   = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
    endtask

    // Stimulus: len low cycles carrying seq (first bit = seq[len-1]), then one high edge
    task automatic drive_window(input logic [7:0] seq, input int len);
        for (int i = 0; i < len; i++) begin
            go  = 1'b0;
            pin = seq[len - 1 - i];
            tick();
        end
        go  = 1'b1;
        pin = 1'($urandom);
        tick();
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        go   = 1'b1;
        pin  = 1'b0;
        for (int n = 0; n < 4; n++) di[n] = 16'h1357;
        model_reset();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (err_w !== 1'b1) begin errors++; $display("FAIL reset_err actual=%b required=1", err_w); end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (get_do(n) !== 16'h0000)
                begin errors++; $display("FAIL reset_do%0d actual=%h required=0000", n, get_do(n)); end
        end
        rst_  = 1'b1;
        di[0] = 16'h00F8;
        tick();
        checks++;
        if (do0 !== 16'h00F8) begin errors++; $display("FAIL release_do0 actual=%h required=00f8", do0); end
        checks++;
        if (err_w !== 1'b1) begin errors++; $display("FAIL release_err actual=%b required=1", err_w); end
        for (int n = 1; n < 4; n++) begin
            checks++;
            if (get_do(n) !== exp_do[n])
                begin errors++; $display("FAIL release_do%0d actual=%h required=%h", n, get_do(n), exp_do[n]); end
        end
        // Asynchronous reassertion, checked before any clock edge
        #2 rst_ = 1'b0;
        #1;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (get_do(n) !== 16'h0000)
                begin errors++; $display("FAIL async_do%0d actual=%h required=0000", n, get_do(n)); end
        end
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        // Partial window interrupted by reset must be discarded
        go  = 1'b0;
        pin = 1'b0;
        repeat (3) tick();
        #2 rst_ = 1'b0;
        go = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        drive_window(8'b0_11_010, 6);
        di[3] = 16'h1234;
        tick();
        tick();
        checks++;
        if (do3 !== 16'hEDCC) begin errors++; $display("FAIL midreset_do3 actual=%h required=edcc", do3); end
        checks++;
        if (err_w !== 1'b1) begin errors++; $display("FAIL midreset_err actual=%b required=1", err_w); end
    endtask

    task automatic test_valid_program();
        logic [5:0] seq;
        do_reset();
        di[0] = 16'h00F8;
        seq   = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            go  = 1'b0;
            pin = seq[5 - i];
            tick();
            checks++;
            if (err_w !== 1'b1) begin errors++; $display("FAIL valid_err_c%0d actual=%b required=1", i, err_w); end
        end
        go = 1'b1;
        tick();
        checks++;
        if (do0 !== 16'h00F8) begin errors++; $display("FAIL valid_do0_e1 actual=%h required=00f8", do0); end
        tick();
        checks++;
        if (do0 !== 16'h0000) begin errors++; $display("FAIL valid_do0_e2 actual=%h required=0000", do0); end
        checks++;
        if (err_w !== 1'b1) begin errors++; $display("FAIL valid_err_end actual=%b required=1", err_w); end
    endtask

    task automatic test_opcode_error();
        logic [5:0] seq;
        do_reset();
        di[0] = 16'hFF00;
        seq   = 6'b100111;
        for (int i = 0; i < 6; i++) begin
            go  = 1'b0;
            pin = seq[5 - i];
            for (int n = 1; n < 4; n++) di[n] = rand_sample();
            tick();
            checks++;
            if (err_w !== 1'b0) begin errors++; $display("FAIL opcode_err_c%0d actual=%b required=0", i, err_w); end
        end
        go = 1'b1;
        repeat (3) begin
            for (int n = 1; n < 4; n++) di[n] = rand_sample();
            tick();
            checks++;
            if (do0 !== 16'hFF00) begin errors++; $display("FAIL opcode_do0 actual=%h required=ff00", do0); end
            checks++;
            if (err_w !== 1'b0) begin errors++; $display("FAIL opcode_err_hold actual=%b required=0", err_w); end
            for (int n = 1; n < 4; n++) begin
                checks++;
                if (get_do(n) !== exp_do[n])
                    begin errors++; $display("FAIL opcode_do%0d actual=%h required=%h", n, get_do(n), exp_do[n]); end
            end
        end
    endtask

    task automatic test_short_window();
        logic [5:0] seq;
        do_reset();
        go  = 1'b0;
        pin = 1'b0;
        repeat (3) tick();
        checks++;
        if (err_w !== 1'b1) begin errors++; $display("FAIL short_err_in actual=%b required=1", err_w); end
        go = 1'b1;
        tick();
        checks++;
        if (err_w !== 1'b0) begin errors++; $display("FAIL short_err_rise actual=%b required=0", err_w); end
        tick();
        checks++;
        if (err_w !== 1'b0) begin errors++; $display("FAIL short_err_hold actual=%b required=0", err_w); end
        seq = 6'b010001;
        for (int i = 0; i < 6; i++) begin
            go  = 1'b0;
            pin = seq[5 - i];
            tick();
            checks++;
            if (err_w !== 1'b1) begin errors++; $display("FAIL short_clear_c%0d actual=%b required=1", i, err_w); end
        end
        go    = 1'b1;
        di[2] = 16'h5A5A;
        tick();
        tick();
        checks++;
        if (do2 !== 16'h0000) begin errors++; $display("FAIL short_follow_do2 actual=%h required=0000", do2); end
    endtask

    task automatic test_long_window();
        logic [6:0] seq;
        do_reset();
        di[1] = 16'h8123;
        seq   = 7'b0011100;
        for (int i = 0; i < 7; i++) begin
            go  = 1'b0;
            pin = seq[6 - i];
            tick();
            checks++;
            if (err_w !== ((i == 6) ? 1'b0 : 1'b1))
                begin errors++; $display("FAIL long_err_c%0d actual=%b required=%b", i, err_w, (i != 6)); end
        end
        go = 1'b1;
        tick();
        tick();
        checks++;
        if (err_w !== 1'b0) begin errors++; $display("FAIL long_err_after actual=%b required=0", err_w); end
        checks++;
        if (do1 !== 16'h8123) begin errors++; $display("FAIL long_do1 actual=%h required=8123", do1); end
    endtask

    task automatic test_arith();
        do_reset();
        drive_window(8'b0_01_101, 6);
        drive_window(8'b0_10_011, 6);
        di[1] = 16'h4001;
        di[2] = 16'hFF00;
        tick();
        checks++;
        if (do1 !== EXP_X2_4001) begin errors++; $display("FAIL arith_x2 actual=%h required=%h", do1, EXP_X2_4001); end
        checks++;
        if (do2 !== 16'hFF80) begin errors++; $display("FAIL arith_asr1 actual=%h required=ff80", do2); end
        // Every mode on every channel against corner-heavy samples
        for (int m = 0; m < 8; m++) begin
            for (int ch = 0; ch < 4; ch++) drive_window({2'b00, 2'(ch), 3'(m)}, 6);
            repeat (6) begin
                for (int n = 0; n < 4; n++) di[n] = rand_sample();
                tick();
                for (int n = 0; n < 4; n++) begin
                    checks++;
                    if (get_do(n) !== exp_do[n])
                        begin errors++; $display("FAIL arith_m%0d_do%0d actual=%h required=%h", m, n, get_do(n), exp_do[n]); end
                end
            end
        end
    endtask

    task automatic test_random();
        int gap;
        int len;
        int sel;
        do_reset();
        for (int w = 0; w < 60; w++) begin
            gap = $urandom_range(1, 3);
            sel = $urandom_range(0, 9);
            len = (sel < 6) ? 6 : (sel < 8) ? $urandom_range(1, 5) : $urandom_range(7, 8);
            for (int c = 0; c < gap + len; c++) begin
                go = (c < gap) ? 1'b1 : 1'b0;
                if (c == gap) pin = ($urandom_range(0, 7) == 0);
                else          pin = 1'($urandom);
                for (int n = 0; n < 4; n++) di[n] = rand_sample();
                tick();
                checks++;
                if (err_w !== exp_err)
                    begin errors++; $display("FAIL rand_err w%0d c%0d actual=%b required=%b", w, c, err_w, exp_err); end
                for (int n = 0; n < 4; n++) begin
                    checks++;
                    if (get_do(n) !== exp_do[n])
                        begin errors++; $display("FAIL rand_do%0d w%0d c%0d actual=%h required=%h", n, w, c, get_do(n), exp_do[n]); end
                end
            end
        end
    endtask

    initial begin
        rst_ = 1'b0;
        go   = 1'b1;
        pin  = 1'b0;
        for (int n = 0; n < 4; n++) di[n] = 16'h0000;
        model_reset();
        #1;
        test_reset();
        test_valid_program();
        test_opcode_error();
        test_short_window();
        test_long_window();
        test_arith();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
